// File: rtl/event_sync_arb_pkg.sv
// event_sync_pkg: shared constants, width helper and parameter-legality check for event_sync_arb.
package event_sync_pkg;
  localparam int MIN_SYNC_STAGES = 2;
  localparam int MAX_SYNC_STAGES = 4;
  localparam int MAX_CHANNELS = 16;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  function automatic bit params_ok(input int channels, input int sync_stages, input int cnt_w);
    return (channels >= 1) && (channels <= MAX_CHANNELS) &&
           (sync_stages >= MIN_SYNC_STAGES) && (sync_stages <= MAX_SYNC_STAGES) && (cnt_w >= 1);
  endfunction
endpackage

// File: rtl/event_sync_arb_sync_toggle_rx.sv
// sync_toggle_rx: one channel of toggle receive - synchroniser chain, history flop, single-cycle event pulse.
module sync_toggle_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic toggle_i,
  output logic ev_o
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic hist_q;
  assign sync_d = {sync_q[SYNC_STAGES-2:0], toggle_i};
  assign ev_o = sync_q[SYNC_STAGES-1] ^ hist_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= sync_q[SYNC_STAGES-1];
    end
endmodule

// File: rtl/event_sync_arb.sv
// event_sync_arb: toggle-event receiver with per-channel saturating counters and a round-robin valid/ready port.
// Optional sticky overflow flags are built when EVENT_SYNC_ARB_OVF_EN is defined.
module event_sync_arb
  import event_sync_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W = 3,
  localparam int CHAN_W = clog2_min1(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] toggle_in,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [CHAN_W-1:0]   evt_chan,
  output logic [CHANNELS-1:0] ovf,
  input  logic [CHANNELS-1:0] ovf_clr
);
  if (!params_ok(CHANNELS, SYNC_STAGES, CNT_W)) begin : g_bad_params
    $error("event_sync_arb: illegal CHANNELS/SYNC_STAGES/CNT_W");
  end
  logic [CHANNELS-1:0] nz;
  logic [CHAN_W-1:0] sel, sel_hi, sel_lo, rr_q, rr_d, chan_q, chan_d;
  logic any_hi, load, valid_q, valid_d;
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic ev, ld, sat;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    sync_toggle_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
      .clk     (clk),
      .rst_n   (rst_n),
      .toggle_i(toggle_in[g]),
      .ev_o    (ev)
    );
    assign ld = load & (sel == CHAN_W'(g));
    assign sat = &cnt_q;
    // ev and ld together cancel, so an edge coinciding with a load is never lost
    assign cnt_d = (ev & ~ld) ? (sat ? cnt_q : cnt_q + 1'b1) :
                   (~ev & ld) ? cnt_q - 1'b1 : cnt_q;
    assign nz[g] = |cnt_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
`ifdef EVENT_SYNC_ARB_OVF_EN
    logic ovf_q, ovf_d;
    assign ovf_d = (ev & ~ld & sat) | (ovf_q & ~ovf_clr[g]);
    assign ovf[g] = ovf_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ovf_q <= 1'b0;
      else ovf_q <= ovf_d;
`else
    assign ovf[g] = 1'b0;
`endif
  end
`ifndef EVENT_SYNC_ARB_OVF_EN
  logic unused_ovf_clr;
  assign unused_ovf_clr = ^ovf_clr;
`endif
  // lowest pending channel at/above rr_q wins, else lowest pending overall (wrap)
  always_comb begin
    sel_hi = '0;
    sel_lo = '0;
    any_hi = 1'b0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (nz[k]) sel_lo = CHAN_W'(k);
      if (nz[k] && (CHAN_W'(k) >= rr_q)) begin
        sel_hi = CHAN_W'(k);
        any_hi = 1'b1;
      end
    end
  end
  assign sel = any_hi ? sel_hi : sel_lo;
  assign load = (~valid_q | evt_ready) & (|nz);
  assign valid_d = load | (valid_q & ~evt_ready);
  assign chan_d = load ? sel : chan_q;
  assign rr_d = !load ? rr_q : (sel == CHAN_W'(CHANNELS - 1)) ? '0 : sel + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q <= 1'b0;
      chan_q <= '0;
      rr_q <= '0;
    end else begin
      valid_q <= valid_d;
      chan_q <= chan_d;
      rr_q <= rr_d;
    end
  assign evt_valid = valid_q;
  assign evt_chan = chan_q;
endmodule

// File: tb/tb_event_sync_arb.sv
// tb_event_sync_arb: directed self-checking bench for event_sync_arb (CHANNELS=4, SYNC_STAGES=2, CNT_W=3).
module tb_event_sync_arb;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] toggle_in;
  logic evt_valid;
  logic evt_ready;
  logic [1:0] evt_chan;
  logic [3:0] ovf;
  logic [3:0] ovf_clr;
  int n_assert = 0;
  int n_fail = 0;
  int xfers [4] = '{0, 0, 0, 0};
  int base;
  int seq [6];

  event_sync_arb #(.CHANNELS(4), .SYNC_STAGES(2), .CNT_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .toggle_in(toggle_in),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_chan (evt_chan),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n && evt_valid && evt_ready) xfers[evt_chan] = xfers[evt_chan] + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // reset with ch1 already high: one event expected 4 cycles after release
    rst_n = 1'b0;
    toggle_in = 4'b0010;
    evt_ready = 1'b0;
    ovf_clr = 4'b0000;
    tick(3);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_chan", int'(evt_chan), 0);
    chk("rst_ovf", int'(ovf), 0);
    rst_n = 1'b1;
    tick(3);
    chk("rel_valid_early", int'(evt_valid), 0);
    tick(1);
    chk("rel_valid", int'(evt_valid), 1);
    chk("rel_chan", int'(evt_chan), 1);
    evt_ready = 1'b1;
    tick(1);
    chk("rel_drain", int'(evt_valid), 0);
    tick(10);
    chk("rel_quiet", int'(evt_valid), 0);
    chk("rel_count", xfers[1], 1);

    // single-channel latency on ch2
    toggle_in[2] = ~toggle_in[2];
    tick(3);
    chk("lat_early", int'(evt_valid), 0);
    tick(1);
    chk("lat_valid", int'(evt_valid), 1);
    chk("lat_chan", int'(evt_chan), 2);
    tick(1);
    chk("lat_one_cycle", int'(evt_valid), 0);

    // one ch3 event brings the round-robin pointer back to 0
    toggle_in[3] = ~toggle_in[3];
    tick(8);
    chk("ch3_count", xfers[3], 1);

    // round-robin: two events each on ch0, ch1, ch3 under backpressure
    evt_ready = 1'b0;
    toggle_in = toggle_in ^ 4'b1011;
    tick(2);
    toggle_in = toggle_in ^ 4'b1011;
    tick(8);
    seq = '{0, 1, 3, 0, 1, 3};
    evt_ready = 1'b1;
    #1;
    chk("rr_valid0", int'(evt_valid), 1);
    chk("rr_chan0", int'(evt_chan), seq[0]);
    for (int i = 1; i < 6; i++) begin
      tick(1);
      chk($sformatf("rr_valid%0d", i), int'(evt_valid), 1);
      chk($sformatf("rr_chan%0d", i), int'(evt_chan), seq[i]);
    end
    tick(1);
    chk("rr_empty", int'(evt_valid), 0);

    // backpressure: held ch2 stays stable while ch0 x3 and ch3 x1 accumulate
    evt_ready = 1'b0;
    toggle_in[2] = ~toggle_in[2];
    tick(4);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("bp_valid", int'(evt_valid), 1);
      chk("bp_chan", int'(evt_chan), 2);
      if (i == 2 || i == 5 || i == 8) toggle_in[0] = ~toggle_in[0];
      if (i == 11) toggle_in[3] = ~toggle_in[3];
    end
    seq = '{2, 3, 0, 0, 0, 0};
    evt_ready = 1'b1;
    #1;
    chk("bp_seq0", int'(evt_chan), 2);
    for (int i = 1; i < 5; i++) begin
      tick(1);
      chk($sformatf("bp_seq_valid%0d", i), int'(evt_valid), 1);
      chk($sformatf("bp_seq%0d", i), int'(evt_chan), seq[i]);
    end
    tick(1);
    chk("bp_empty", int'(evt_valid), 0);

    // saturation: 9 ch1 events, one held in the output register, counter caps at 7
    evt_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      toggle_in[1] = ~toggle_in[1];
      tick(2);
    end
    tick(4);
`ifdef EVENT_SYNC_ARB_OVF_EN
    chk("ovf_set", int'(ovf), 4'b0010);
`else
    chk("ovf_tied", int'(ovf), 0);
`endif
    base = xfers[1];
    evt_ready = 1'b1;
    tick(12);
    chk("sat_count", xfers[1] - base, 8);
    chk("sat_empty", int'(evt_valid), 0);
    ovf_clr = 4'b0010;
    tick(1);
    ovf_clr = 4'b0000;
    tick(1);
    chk("ovf_clear", int'(ovf), 0);

    // ch0 edge coinciding with the load of the previous ch0 event
    base = xfers[0];
    toggle_in[0] = ~toggle_in[0];
    tick(1);
    toggle_in[0] = ~toggle_in[0];
    tick(3);
    chk("sim_valid_a", int'(evt_valid), 1);
    chk("sim_chan_a", int'(evt_chan), 0);
    tick(1);
    chk("sim_valid_b", int'(evt_valid), 1);
    chk("sim_chan_b", int'(evt_chan), 0);
    tick(1);
    chk("sim_empty", int'(evt_valid), 0);
    tick(2);
    chk("sim_count", xfers[0] - base, 2);

    // mid-operation reset discards pending events
    evt_ready = 1'b0;
    toggle_in = toggle_in ^ 4'b1110;
    tick(6);
    chk("mid_pre_valid", int'(evt_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_async_valid", int'(evt_valid), 0);
    chk("mid_async_chan", int'(evt_chan), 0);
    toggle_in = 4'b0000;
    tick(2);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    base = xfers[0] + xfers[1] + xfers[2] + xfers[3];
    tick(15);
    chk("mid_no_events", xfers[0] + xfers[1] + xfers[2] + xfers[3] - base, 0);
    chk("mid_valid_low", int'(evt_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
